elevator_step_ctrl: RTL and testbench

Parametrised elevator car controller: keeps the current floor as a one-hot register, accepts a one-hot destination and steps the car one floor per STEP_TICKS slow ticks. It drives motor_on/motor_dir for the motor driver and holds the door for a dwell period on arrival. It sits between the request queue, which supplies `des`, and the motor PWM driver, which consumes `motor_on`/`motor_dir`. It replaces the fixed 4-floor stepping logic.

---
 rtl/elevator_step_ctrl.sv | 146 ++++++++++++++
 tb/tb_elevator_step_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/elevator_step_ctrl.sv
// Elevator car stepper: one-hot floor register, latched one-hot target, one floor per STEP_TICKS ticks.
// Optional door dwell on arrival when ELEV_DOOR_EN is defined.
module elevator_step_ctrl #(
    parameter int FLOORS     = 4,
    parameter int STEP_TICKS = 4,
    parameter int DOOR_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              go,
    input  logic [FLOORS-1:0] des,
    output logic [FLOORS-1:0] floor,
    output logic              motor_on,
    output logic              motor_dir,
    output logic              door_open,
    output logic              arrived,
    output logic              req_err,
    output logic              busy
);

`ifdef ELEV_DOOR_EN
    localparam int CMAX = (STEP_TICKS > DOOR_TICKS) ? STEP_TICKS : DOOR_TICKS;
`else
    localparam int CMAX = STEP_TICKS;
`endif
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_TICKS - 1);
`ifdef ELEV_DOOR_EN
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
`endif

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t            state, state_n;
    logic [FLOORS-1:0] tgt, tgt_n, floor_n, step;
    logic [CW-1:0]     cnt, cnt_n;
    logic              motor_on_n, motor_dir_n, door_open_n, arrived_n, req_err_n;
    logic              des_ok;

    // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
    assign des_ok = (des != '0) && ((des & (des - FLOORS'(1))) == '0);
    assign step   = motor_dir ? (floor << 1) : (floor >> 1);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            floor     <= FLOORS'(1);
            tgt       <= '0;
            cnt       <= '0;
            motor_on  <= 1'b0;
            motor_dir <= 1'b0;
            door_open <= 1'b0;
            arrived   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            state     <= state_n;
            floor     <= floor_n;
            tgt       <= tgt_n;
            cnt       <= cnt_n;
            motor_on  <= motor_on_n;
            motor_dir <= motor_dir_n;
            door_open <= door_open_n;
            arrived   <= arrived_n;
            req_err   <= req_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        floor_n     = floor;
        tgt_n       = tgt;
        cnt_n       = cnt;
        motor_on_n  = motor_on;
        motor_dir_n = motor_dir;
        door_open_n = door_open;
        arrived_n   = 1'b0;
        req_err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (!des_ok) begin
                        req_err_n = 1'b1;
                    end else if (des == floor) begin
                        arrived_n = 1'b1;
`ifdef ELEV_DOOR_EN
                        state_n     = DOOR;
                        door_open_n = 1'b1;
                        cnt_n       = '0;
`endif
                    end else begin
                        tgt_n       = des;
                        motor_dir_n = (des > floor);
                        motor_on_n  = 1'b1;
                        cnt_n       = '0;
                        state_n     = MOVE;
                    end
                end
            end
            MOVE: begin
                if (!go) begin
                    motor_on_n = 1'b0;
                end else begin
                    motor_on_n = 1'b1;
                    if (tick) begin
                        if (cnt == STEP_LAST) begin
                            floor_n = step;
                            cnt_n   = '0;
                            if (step == tgt) begin
                                motor_on_n = 1'b0;
                                arrived_n  = 1'b1;
`ifdef ELEV_DOOR_EN
                                state_n     = DOOR;
                                door_open_n = 1'b1;
`else
                                state_n     = IDLE;
`endif
                            end
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
            end
            DOOR: begin
`ifdef ELEV_DOOR_EN
                // dwell runs to completion regardless of go
                if (tick) begin
                    if (cnt == DOOR_LAST) begin
                        door_open_n = 1'b0;
                        cnt_n       = '0;
                        state_n     = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_elevator_step_ctrl.sv
// Bench for elevator_step_ctrl: directed scenarios then random traffic, every cycle compared
// against an integer-position travel model.
module tb_elevator_step_ctrl;
    localparam int FLOORS = 4;
    localparam int STEP   = 3;
    localparam int DWELL  = 2;
`ifdef ELEV_DOOR_EN
    localparam bit DOOR_EN = 1'b1;
`else
    localparam bit DOOR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1, tick = 1'b0, go = 1'b0;
    logic [FLOORS-1:0] des = '0;
    logic [FLOORS-1:0] floor;
    logic              motor_on, motor_dir, door_open, arrived, req_err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // model: position as a floor index, phase 0=parked 1=travelling 2=door dwell
    int m_pos, m_tgt, m_phase, m_ticks;
    bit m_on, m_dir, m_door, m_arr, m_err;

    elevator_step_ctrl #(.FLOORS(FLOORS), .STEP_TICKS(STEP), .DOOR_TICKS(DWELL)) dut (
        .clk(clk), .rst(rst), .tick(tick), .go(go), .des(des),
        .floor(floor), .motor_on(motor_on), .motor_dir(motor_dir), .door_open(door_open),
        .arrived(arrived), .req_err(req_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit t, input bit g, input logic [FLOORS-1:0] d);
        int idx;
        m_arr = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_pos = 0; m_tgt = 0; m_phase = 0; m_ticks = 0;
            m_on = 0; m_dir = 0; m_door = 0;
            return;
        end
        case (m_phase)
            0: if (g) begin
                if ($countones(d) != 1) m_err = 1'b1;
                else begin
                    idx = 0;
                    for (int i = 0; i < FLOORS; i++) if (d[i]) idx = i;
                    if (idx == m_pos) begin
                        m_arr = 1'b1;
                        if (DOOR_EN) begin m_phase = 2; m_door = 1; m_ticks = 0; end
                    end else begin
                        m_tgt = idx; m_dir = (idx > m_pos); m_on = 1; m_ticks = 0; m_phase = 1;
                    end
                end
            end
            1: if (!g) m_on = 0;
               else begin
                   m_on = 1;
                   if (t) begin
                       m_ticks++;
                       if (m_ticks == STEP) begin
                           m_ticks = 0;
                           m_pos = m_dir ? m_pos + 1 : m_pos - 1;
                           if (m_pos == m_tgt) begin
                               m_on = 0; m_arr = 1;
                               m_phase = DOOR_EN ? 2 : 0;
                               m_door = DOOR_EN;
                           end
                       end
                   end
               end
            default: if (t) begin
                m_ticks++;
                if (m_ticks == DWELL) begin m_door = 0; m_ticks = 0; m_phase = 0; end
            end
        endcase
    endtask

    task automatic cyc(input bit r, input bit t, input bit g, input logic [FLOORS-1:0] d);
        logic [FLOORS-1:0] ef;
        rst = r; tick = t; go = g; des = d;
        @(posedge clk);
        model(r, t, g, d);
        #1;
        ef = '0;
        ef[m_pos] = 1'b1;
        chk("floor", floor, ef);
        chk("motor_on", motor_on, m_on);
        chk("motor_dir", motor_dir, m_dir);
        chk("door_open", door_open, m_door);
        chk("arrived", arrived, m_arr);
        chk("req_err", req_err, m_err);
        chk("busy", busy, m_phase != 0);
        chk("arr_err_excl", arrived & req_err, 1'b0);
    endtask

    initial begin
        logic [FLOORS-1:0] d;
        // reset
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);
        chk("rst_floor", floor, 4'b0001);
        chk("rst_busy", busy, 1'b0);
        // ground to top; a changed des during travel is ignored
        cyc(0, 1, 1, 4'b1000);
        chk("start_on", motor_on, 1'b1);
        chk("start_dir", motor_dir, 1'b1);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 4'b0001);
        chk("arr_top_floor", floor, 4'b1000);
        chk("arr_top_pulse", arrived, 1'b1);
        chk("arr_top_door", door_open, DOOR_EN);
        cyc(0, 1, 0, '0);
        cyc(0, 1, 0, '0);
        chk("idle_after_door", busy, 1'b0);
        // malformed requests
        cyc(0, 1, 1, 4'b0110); chk("err_0110", req_err, 1'b1);
        cyc(0, 1, 1, 4'b0000); chk("err_0000", req_err, 1'b1);
        cyc(0, 1, 1, 4'b1111); chk("err_1111", req_err, 1'b1);
        chk("err_floor", floor, 4'b1000);
        // head down, halt at cnt=1, resume
        cyc(0, 1, 1, 4'b0001);
        cyc(0, 1, 1, 4'b0001);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 4'b0001);
        chk("halt_on", motor_on, 1'b0);
        chk("halt_floor", floor, 4'b1000);
        cyc(0, 1, 1, 4'b0001);
        cyc(0, 1, 1, 4'b0001);
        chk("resume_floor", floor, 4'b0100);
        // reset mid-travel
        cyc(0, 1, 1, 4'b0001);
        cyc(1, 1, 1, 4'b0001);
        chk("rst_move_floor", floor, 4'b0001);
        chk("rst_move_on", motor_on, 1'b0);
        chk("rst_move_busy", busy, 1'b0);
        // same-floor request
        cyc(0, 1, 1, 4'b0001);
        chk("same_arr", arrived, 1'b1);
        chk("same_on", motor_on, 1'b0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                d = '0;
                d[$urandom_range(0, FLOORS - 1)] = 1'b1;
            end else d = FLOORS'($urandom);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) != 0, d);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
